prog_loader: RTL and testbench

//  Writer side of the instruction-memory interface: receives a byte stream from the host,

---
 rtl/prog_loader.sv | 183 ++++++++++++++++++
 tb/tb_prog_loader.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//   Writer side of the instruction-memory interface. Receives a framed byte
//   stream from the host, packs it into W-bit machine-code words and writes
//   them to instruction RAM at addresses 0..N-1. Keeps the core held in reset
//   until a load finishes cleanly.
//
//   Frame: LEN_LO, LEN_HI (16-bit N, little-endian), then N x {LO, HI}.
//          word = {HI[0], LO}; HI[7:1] must be zero.
//
//   Optional feature (macro PROG_LOADER_CHECKSUM_EN): one trailer byte after
//   the payload must equal the XOR of all LO/HI payload bytes.
//
// Ports
//   clk        in   system clock, all state on posedge
//   reset      in   asynchronous, active-low
//   start      in   1-cycle pulse, begins a load from IDLE/DONE/ERR
//   in_data    in   host byte
//   in_valid   in   host byte present
//   in_ready   out  loader accepts a byte (transfer = in_valid & in_ready)
//   im_wr_en   out  instruction memory write strobe, one cycle per word
//   im_addr    out  write address (word index)
//   im_wdata   out  write data
//   core_hold  out  1 = hold core in reset
//   load_done  out  sticky, last load completed cleanly
//   err        out  sticky, last load aborted
// ---------------------------------------------------------------------------
module prog_loader #(
  parameter int D = 12,
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         im_wr_en,
  output logic [D-1:0] im_addr,
  output logic [W-1:0] im_wdata,
  output logic         core_hold,
  output logic         load_done,
  output logic         err
);

  typedef enum logic [3:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_W_LO, S_W_HI, S_FIN, S_CHK, S_DONE, S_ERR
  } state_e;

  // Largest legal word count: the full address space.
  localparam logic [16:0] CAP = 17'(1) << D;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_e AFTER_LAST = S_CHK;
`else
  localparam state_e AFTER_LAST = S_FIN;
`endif

  state_e         state_q, state_d;
  logic [15:0]    len_q;
  logic [D:0]     cnt_q;      // one extra bit so N = 2**D does not wrap
  logic [7:0]     lo_q;
  logic           wr_en_q;
  logic [D-1:0]   addr_q;
  logic [W-1:0]   wdata_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]     chk_q;
`endif

  logic           xfer;
  logic           start_ok;
  logic           oversize;
  logic           len_zero;
  logic           hi_bad;
  logic           last_word;
  logic           chk_match;
  logic [D:0]     cnt_inc;

  assign in_ready  = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                     (state_q == S_W_LO)   || (state_q == S_W_HI)   ||
                     (state_q == S_CHK);
  assign xfer      = in_valid & in_ready;
  assign start_ok  = start & ((state_q == S_IDLE) || (state_q == S_DONE) ||
                              (state_q == S_ERR));

  // Length checks look at the HI byte on the wire together with the stored LO.
  assign oversize  = {1'b0, in_data, len_q[7:0]} > CAP;
  assign len_zero  = ({in_data, len_q[7:0]} == 16'd0);
  assign hi_bad    = |in_data[7:1];
  assign cnt_inc   = cnt_q + 1'b1;
  assign last_word = (17'(cnt_inc) == {1'b0, len_q});

`ifdef PROG_LOADER_CHECKSUM_EN
  assign chk_match = (in_data == chk_q);
`else
  assign chk_match = 1'b0;
`endif

  // NOTE: every combinational output gets a default before the case, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_LEN_LO;
      S_LEN_LO: if (xfer) state_d = S_LEN_HI;
      S_LEN_HI: if (xfer) begin
        if (oversize)      state_d = S_ERR;
        else if (len_zero) state_d = AFTER_LAST;
        else               state_d = S_W_LO;
      end
      S_W_LO:   if (xfer) state_d = S_W_HI;
      S_W_HI:   if (xfer) begin
        if (hi_bad)         state_d = S_ERR;
        else if (last_word) state_d = AFTER_LAST;
        else                state_d = S_W_LO;
      end
      S_FIN:    state_d = S_DONE;
      S_CHK:    if (xfer) state_d = chk_match ? S_DONE : S_ERR;
      S_DONE,
      S_ERR:    if (start) state_d = S_LEN_LO;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      lo_q    <= '0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      wr_en_q <= 1'b0;
      if (start_ok) begin
        cnt_q <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
        chk_q <= '0;
`endif
      end
      if (xfer) begin
        unique case (state_q)
          S_LEN_LO: len_q[7:0]  <= in_data;
          S_LEN_HI: len_q[15:8] <= in_data;
          S_W_LO: begin
            lo_q <= in_data;
`ifdef PROG_LOADER_CHECKSUM_EN
            chk_q <= chk_q ^ in_data;
`endif
          end
          S_W_HI: begin
            // A word with reserved bits set is dropped, not written.
            if (!hi_bad) begin
              wr_en_q <= 1'b1;
              addr_q  <= cnt_q[D-1:0];
              wdata_q <= W'({in_data[0], lo_q});
              cnt_q   <= cnt_inc;
`ifdef PROG_LOADER_CHECKSUM_EN
              chk_q   <= chk_q ^ in_data;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign im_wr_en  = wr_en_q;
  assign im_addr   = addr_q;
  assign im_wdata  = wdata_q;
  assign core_hold = (state_q != S_DONE);
  assign load_done = (state_q == S_DONE);
  assign err       = (state_q == S_ERR);

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
//   Self-checking bench for prog_loader (D=12, W=9). Each frame is decoded by
//   a behavioural model that walks the byte list and predicts the sequence of
//   RAM writes and the final outcome; a monitor collects the writes the DUT
//   actually issues. Checksum scenarios are built when
//   PROG_LOADER_CHECKSUM_EN is defined.
// ---------------------------------------------------------------------------
module tb_prog_loader;

  localparam int D = 12;
  localparam int W = 9;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic         im_wr_en;
  logic [D-1:0] im_addr;
  logic [W-1:0] im_wdata;
  logic         core_hold;
  logic         load_done;
  logic         err;

  prog_loader #(.D(D), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .im_wr_en  (im_wr_en),
    .im_addr   (im_addr),
    .im_wdata  (im_wdata),
    .core_hold (core_hold),
    .load_done (load_done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int           total = 0;
  int           bad   = 0;
  logic [20:0]  wq[$];     // observed writes {addr, data}
  logic [20:0]  eq[$];     // expected writes {addr, data}
  logic [7:0]   fr[$];     // current frame bytes
  bit           exp_done;
  bit           exp_err;
  int           n_send;
  bit           stuck;

  always @(negedge clk) if (im_wr_en === 1'b1) wq.push_back({im_addr, im_wdata});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame decoder: length, then words until done or a reserved-bit fault.
  task automatic model();
    int n, idx;
    logic [7:0] x, lo, hi;
    eq.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    n = int'(fr[1]) * 256 + int'(fr[0]);
    if (n > (1 << D)) begin
      exp_err = 1'b1;
      n_send  = 2;
      return;
    end
    idx = 2;
    x   = 8'h00;
    for (int k = 0; k < n; k++) begin
      lo = fr[idx];
      hi = fr[idx + 1];
      idx += 2;
      if (hi > 8'd1) begin
        exp_err = 1'b1;
        n_send  = idx;
        return;
      end
      eq.push_back({12'(k), hi[0], lo});
      x ^= lo ^ hi;
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    n_send = idx + 1;
    if (fr[idx] == x) exp_done = 1'b1;
    else              exp_err  = 1'b1;
`else
    n_send   = idx;
    exp_done = 1'b1;
`endif
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b1;     // a byte offered alongside start must not be consumed
    in_data  = 8'hEE;
    wq.delete();
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int budget;
    if (stuck) return;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    budget   = 0;
    while (in_ready !== 1'b1 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check("byte_accept", in_ready, 1);
    if (in_ready !== 1'b1) begin
      stuck    = 1'b1;
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(load_done === 1'b1 || err === 1'b1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("end_reached", load_done | err, 1);
  endtask

  task automatic compare_frame(input string tag);
    check($sformatf("%s_nwr", tag), wq.size(), eq.size());
    for (int i = 0; i < eq.size() && i < wq.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), wq[i], eq[i]);
    check($sformatf("%s_done", tag), load_done, exp_done);
    check($sformatf("%s_err", tag), err, exp_err);
    check($sformatf("%s_hold", tag), core_hold, !exp_done);
    if (exp_err) check($sformatf("%s_rdy", tag), in_ready, 0);
  endtask

  task automatic send_frame(input bit gaps);
    stuck = 1'b0;
    model();
    for (int i = 0; i < n_send; i++) send_byte(fr[i], gaps);
  endtask

  task automatic run_frame(input string tag, input bit gaps);
    start_pulse();
    send_frame(gaps);
    wait_end();
    compare_frame(tag);
  endtask

  task automatic add_trailer(input bit good);
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] x = 8'h00;
    for (int i = 2; i < fr.size(); i++) x ^= fr[i];
    fr.push_back(good ? x : ~x);
`endif
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h55;
    stuck    = 1'b0;

    // Reset state with a byte offered.
    repeat (3) @(negedge clk);
    check("rst_ready", in_ready, 0);
    check("rst_wr", im_wr_en, 0);
    check("rst_addr", im_addr, 0);
    check("rst_wdata", im_wdata, 0);
    check("rst_hold", core_hold, 1);
    check("rst_done", load_done, 0);
    check("rst_err", err, 0);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("idle_ready", in_ready, 0);

    // Basic load.
`ifdef PROG_LOADER_CHECKSUM_EN
    fr = '{8'h02, 8'h00, 8'h3F, 8'h01, 8'hA5, 8'h00, 8'h9B};
    run_frame("basic", 1'b0);
`else
    fr = '{8'h02, 8'h00, 8'h3F, 8'h01, 8'hA5, 8'h00};
    start_pulse();
    send_frame(1'b0);
    @(negedge clk);
    check("basic_strobe", im_wr_en, 1);
    check("basic_addr1", im_addr, 1);
    check("basic_data1", im_wdata, 9'h0A5);
    check("basic_hold_pre", core_hold, 1);
    check("basic_done_pre", load_done, 0);
    @(negedge clk);
    check("basic_done_post", load_done, 1);
    check("basic_hold_post", core_hold, 0);
    check("basic_strobe_off", im_wr_en, 0);
    compare_frame("basic");
`endif

    // Empty load.
    fr = '{8'h00, 8'h00};
    add_trailer(1'b1);
    run_frame("empty", 1'b0);

    // Oversize length.
    fr = '{8'h01, 8'h10};
    run_frame("oversize", 1'b0);

    // Reserved bits set in HI, then restart from ERR.
    fr = '{8'h01, 8'h00, 8'h12, 8'h02};
    run_frame("reserved", 1'b0);
    start_pulse();
    check("restart_err", err, 0);
    check("restart_hold", core_hold, 1);
    check("restart_ready", in_ready, 1);
    fr = '{8'h01, 8'h00, 8'h34, 8'h01};
    add_trailer(1'b1);
    send_frame(1'b0);
    wait_end();
    compare_frame("restart");

    // Basic stream with random in_valid gaps.
    for (int r = 0; r < 4; r++) begin
      fr = '{8'h02, 8'h00, 8'h3F, 8'h01, 8'hA5, 8'h00};
      add_trailer(1'b1);
      run_frame($sformatf("gaps%0d", r), 1'b1);
    end

    // Reset after word 0 aborts the load.
    start_pulse();
    stuck = 1'b0;
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h3F, 1'b0);
    send_byte(8'h01, 1'b0);
    @(negedge clk);
    check("abort_w0_strobe", im_wr_en, 1);
    reset = 1'b0;
    #1;
    check("abort_hold", core_hold, 1);
    check("abort_done", load_done, 0);
    check("abort_ready", in_ready, 0);
    check("abort_nwr", wq.size(), 1);
    if (wq.size() > 0) check("abort_w0", wq[0], {12'd0, 9'h13F});
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h01;
    repeat (2) @(negedge clk);
    check("abort_idle_ready", in_ready, 0);
    in_valid = 1'b0;

`ifdef PROG_LOADER_CHECKSUM_EN
    // Bad checksum: both words still written, core stays held.
    fr = '{8'h02, 8'h00, 8'h3F, 8'h01, 8'hA5, 8'h00, 8'h9A};
    run_frame("chk_bad", 1'b0);
`endif

    // Random frames, occasional reserved-bit faults and bad checksums.
    for (int r = 0; r < 12; r++) begin
      int n;
      n = $urandom_range(0, 6);
      fr = '{8'(n), 8'h00};
      for (int k = 0; k < n; k++) begin
        fr.push_back(8'($urandom));
        if ($urandom_range(0, 9) == 0) fr.push_back(8'h02 | 8'($urandom));
        else                           fr.push_back({7'b0, 1'($urandom)});
      end
      add_trailer($urandom_range(0, 3) != 0);
      run_frame($sformatf("rnd%0d", r), 1'b1);
    end

    // Full address space: N = 2**D, last address 2**D-1, no wrap.
    fr = '{8'h00, 8'h10};
    for (int k = 0; k < (1 << D); k++) begin
      fr.push_back(8'($urandom));
      fr.push_back({7'b0, 1'($urandom)});
    end
    add_trailer(1'b1);
    run_frame("full", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
